// File: rtl/barrido_digitos_if.sv
// ---------------------------------------------------------------------------
// barrido_digitos_if
// Bundles the display data inputs and the pin-level outputs of the
// multiplexed seven-segment scanner so they travel as one port.
//   valor : 4*N_DIG hex nibbles, nibble 0 is the least significant digit
//   habil : per-digit enable (0 keeps that digit dark)
//   punto : per-digit decimal point request
//   sel   : one-hot digit select (pin polarity)
//   seg   : segments {g,f,e,d,c,b,a} (pin polarity)
//   dp    : decimal point (pin polarity)
//   tick  : one-cycle pulse when the scanner moves to the next digit
// Modports: master drives the data and watches the pins, slave is the scanner.
// ---------------------------------------------------------------------------
interface barrido_digitos_if #(
  parameter int N_DIG = 4
);
  logic [4*N_DIG-1:0] valor;
  logic [N_DIG-1:0]   habil;
  logic [N_DIG-1:0]   punto;
  logic [N_DIG-1:0]   sel;
  logic [6:0]         seg;
  logic               dp;
  logic               tick;

  modport master (output valor, habil, punto, input sel, seg, dp, tick);
  modport slave  (input valor, habil, punto, output sel, seg, dp, tick);
endinterface

// File: rtl/barrido_digitos.sv
// ---------------------------------------------------------------------------
// barrido_digitos
// Time-multiplexed scanner for an N_DIG digit seven-segment display.
// A prescaler splits time into DIV-cycle slots; each slot lights one digit,
// except for its first cycle, which is kept dark so the previous digit's
// pattern never ghosts onto the next one.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   disp : barrido_digitos_if slave (valor/habil/punto in, sel/seg/dp/tick out)
// Parameters:
//   N_DIG   : number of digits (2..8)
//   DIV     : clock cycles per digit slot (2..2^20)
//   ACT_LOW : 1 inverts sel/seg/dp at the pins for common-anode boards
// Optional feature:
//   BARRIDO_BLANCO_CEROS_EN : when defined, leading zeros are blanked
//   (digit 0 is never blanked, the decimal point is still shown).
// ---------------------------------------------------------------------------
module barrido_digitos #(
  parameter int N_DIG   = 4,
  parameter int DIV     = 50000,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  barrido_digitos_if.slave disp
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [PW-1:0]    presc_q;
  logic [IW-1:0]    idx_q;
  logic             tick_q;
  logic [N_DIG-1:0] sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [3:0]       nib;
  logic             habSel;
  logic             ptoSel;
  logic             blanco;
  logic             finSlot;

  // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign finSlot = (presc_q == PW'(DIV - 1));

  // Pick out the nibble, enable and point of the digit currently scanned.
  always_comb begin
    nib    = 4'h0;
    habSel = 1'b0;
    ptoSel = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = disp.valor[4*i +: 4];
        habSel = disp.habil[i];
        ptoSel = disp.punto[i];
      end
    end
  end

`ifdef BARRIDO_BLANCO_CEROS_EN
  // A digit is a leading zero when it and every digit above it are zero;
  // walking from the top down accumulates that condition. Digit 0 always
  // shows so that a value of zero still reads "0".
  always_comb begin
    logic arriba;
    arriba = 1'b1;
    blanco = 1'b0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      arriba = arriba & (disp.valor[4*i +: 4] == 4'h0);
      if ((idx_q == IW'(i)) && (i != 0)) begin
        blanco = arriba;
      end
    end
  end
`else
  assign blanco = 1'b0;
`endif

  // Next pin values. The first cycle of each slot is a dark guard cycle;
  // a disabled digit keeps its select line but shows nothing.
  always_comb begin
    sel_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (presc_q != '0) begin
      sel_d = N_DIG'(1) << idx_q;
      if (habSel) begin
        seg_d = blanco ? 7'h00 : hex7(nib);
        dp_d  = ptoSel;
      end
    end
  end

  // Prescaler, digit index and registered outputs. The index moves on the
  // same edge the prescaler wraps, so tick lands in the presc==0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      sel_q   <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      tick_q <= finSlot;
      if (finSlot) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      sel_q <= sel_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  // Pin polarity is applied only here; tick and internal state stay as-is.
  assign disp.sel  = ACT_LOW ? ~sel_q : sel_q;
  assign disp.seg  = ACT_LOW ? ~seg_q : seg_q;
  assign disp.dp   = ACT_LOW ? ~dp_q  : dp_q;
  assign disp.tick = tick_q;

endmodule

// File: tb/tb_barrido_digitos.sv
// ---------------------------------------------------------------------------
// tb_barrido_digitos
// Directed bench for barrido_digitos with N_DIG=4, DIV=4. dut0 uses
// active-high pins, dut1 (ACT_LOW=1) shares the same data inputs but has
// its own reset so it can be hit asynchronously mid-slot.
// ---------------------------------------------------------------------------
module tb_barrido_digitos;

  logic clk;
  logic rst;
  logic rst1;

  int checks;
  int passes;

  logic [6:0] expSeg [4];
  int         expDp  [4];

  barrido_digitos_if #(.N_DIG(4)) bus0 ();
  barrido_digitos_if #(.N_DIG(4)) bus1 ();

  assign bus1.valor = bus0.valor;
  assign bus1.habil = bus0.habil;
  assign bus1.punto = bus0.punto;

  barrido_digitos #(.N_DIG(4), .DIV(4), .ACT_LOW(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .disp (bus0)
  );

  barrido_digitos #(.N_DIG(4), .DIV(4), .ACT_LOW(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst1),
    .disp (bus1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Drives the shared data inputs.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] h, input logic [3:0] p);
    bus0.valor = v;
    bus0.habil = h;
    bus0.punto = p;
  endtask

  // Resets both scanners for one cycle and releases them on a falling edge.
  task automatic restartScan();
    rst  = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    rst1 = 1'b0;
  endtask

  // Walks 'edges' clock edges after reset release and checks dut0 against
  // the slot pattern: first cycle of each 4-cycle slot dark, then 3 lit.
  task automatic scanCheck(input string tag, input int edges);
    int dig;
    int pos;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk);
      @(negedge clk);
      dig = ((k - 1) / 4) % 4;
      pos = (k - 1) % 4;
      if (pos == 0) begin
        checkOutput($sformatf("%s.sel%0d", tag, k), 32'(bus0.sel), 32'h0);
        checkOutput($sformatf("%s.seg%0d", tag, k), 32'(bus0.seg), 32'h0);
        checkOutput($sformatf("%s.dp%0d",  tag, k), 32'(bus0.dp),  32'h0);
      end else begin
        checkOutput($sformatf("%s.sel%0d", tag, k), 32'(bus0.sel), 32'(4'b0001 << dig));
        checkOutput($sformatf("%s.seg%0d", tag, k), 32'(bus0.seg), 32'(expSeg[dig]));
        if (expDp[dig] >= 0) begin
          checkOutput($sformatf("%s.dp%0d", tag, k), 32'(bus0.dp), 32'(expDp[dig]));
        end
      end
      checkOutput($sformatf("%s.tick%0d", tag, k), 32'(bus0.tick), 32'((k % 4) == 0));
      checkOutput($sformatf("%s.onehot%0d", tag, k), 32'($countones(bus0.sel) <= 1), 32'h1);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    rst1   = 1'b1;
    applyStimulus(16'h1234, 4'hF, 4'h0);

    // Reset state on both polarities.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.sel0",  32'(bus0.sel),  32'h0);
    checkOutput("rst.seg0",  32'(bus0.seg),  32'h0);
    checkOutput("rst.dp0",   32'(bus0.dp),   32'h0);
    checkOutput("rst.tick0", 32'(bus0.tick), 32'h0);
    checkOutput("rst.sel1",  32'(bus1.sel),  32'hF);
    checkOutput("rst.seg1",  32'(bus1.seg),  32'h7F);
    checkOutput("rst.dp1",   32'(bus1.dp),   32'h1);

    // Plain scan of 1234, including the 3->0 wrap.
    expSeg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    expDp  = '{0, 0, 0, 0};
    rst  = 1'b0;
    rst1 = 1'b0;
    scanCheck("scan1234", 18);

    // Digit 2 disabled: select still walks, segments dark.
    applyStimulus(16'h1234, 4'b1011, 4'b0100);
    expSeg = '{7'h66, 7'h4F, 7'h00, 7'h06};
    expDp  = '{0, 0, -1, 0};
    restartScan();
    scanCheck("habil", 16);

    // Decimal point on an enabled digit 2.
    applyStimulus(16'h1234, 4'hF, 4'b0100);
    expSeg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    expDp  = '{0, 0, 1, 0};
    restartScan();
    scanCheck("punto", 16);

    // Leading zeros: blanked only when the optional feature is built in.
    applyStimulus(16'h00A0, 4'hF, 4'h0);
`ifdef BARRIDO_BLANCO_CEROS_EN
    expSeg = '{7'h3F, 7'h77, 7'h00, 7'h00};
`else
    expSeg = '{7'h3F, 7'h77, 7'h3F, 7'h3F};
`endif
    expDp  = '{0, 0, 0, 0};
    restartScan();
    scanCheck("ceros", 16);

    // Active-low board: reset hits mid-slot while digit 2 is lit.
    applyStimulus(16'h1234, 4'hF, 4'h0);
    restartScan();
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("al.sel_d2", 32'(bus1.sel), 32'hB);
    checkOutput("al.seg_d2", 32'(bus1.seg), 32'h24);
    checkOutput("al.dp_d2",  32'(bus1.dp),  32'h1);
    checkOutput("ah.sel_d2", 32'(bus0.sel), 32'h4);
    #2 rst1 = 1'b1;
    #1;
    checkOutput("al.rst_sel",  32'(bus1.sel),  32'hF);
    checkOutput("al.rst_seg",  32'(bus1.seg),  32'h7F);
    checkOutput("al.rst_dp",   32'(bus1.dp),   32'h1);
    checkOutput("al.rst_tick", 32'(bus1.tick), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("al.hold_sel", 32'(bus1.sel), 32'hF);
    rst1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("al.guard_sel", 32'(bus1.sel), 32'hF);
    checkOutput("al.guard_seg", 32'(bus1.seg), 32'h7F);
    @(posedge clk);
    @(negedge clk);
    checkOutput("al.d0_sel", 32'(bus1.sel), 32'hE);
    checkOutput("al.d0_seg", 32'(bus1.seg), 32'h19);
    checkOutput("al.d0_dp",  32'(bus1.dp),  32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
